// File: rtl/divergent_scheduler.sv
// Per-core FETCH..UPDATE sequencer with active-mask divergence and a (PC, mask) reconvergence stack; one state per cycle.
// Stalls in FETCH until fetched and in WAIT while an active LSU is busy; optional SCHED_PERF_EN adds counters.
module divergent_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int STACK_DEPTH       = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]          thread_count,
    input  logic [2:0]                                  fetcher_state,
    input  logic                                        decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0][1:0]           lsu_state,
    input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]   next_pc,
    output logic [PC_BITS-1:0]                          current_pc,
    output logic [THREADS_PER_BLOCK-1:0]                active_mask,
    output logic [2:0]                                  core_state,
`ifdef SCHED_PERF_EN
    output logic [15:0]                                 diverge_count,
    output logic [15:0]                                 wait_cycles,
`endif
    output logic                                        done,
    output logic                                        error
);
    localparam int T   = THREADS_PER_BLOCK;
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t               state, state_nxt;
    logic [PC_BITS-1:0]   pc_nxt;
    logic [T-1:0]         mask_nxt;
    logic                 done_nxt, error_nxt;
    logic [SPW-1:0]       sp, sp_nxt;
    logic [IW-1:0]        tos_idx, push_idx;
    logic                 push;

    logic [PC_BITS-1:0]   stack_pc   [STACK_DEPTH];
    logic [T-1:0]         stack_mask [STACK_DEPTH];

    logic [T-1:0]         launch_mask, busy, mask_lo, mask_hi;
    logic                 have_v1, have_v2, many;
    logic [PC_BITS-1:0]   v1, v2, pc_lo, pc_hi;

    assign core_state = state;
    assign tos_idx    = IW'(sp - SPW'(1));
    assign push_idx   = IW'(sp);

    // Classify next_pc over active lanes: first value, a second distinct value, or more.
    always_comb begin
        launch_mask = '0;
        busy        = '0;
        have_v1     = 1'b0;
        have_v2     = 1'b0;
        many        = 1'b0;
        v1          = '0;
        v2          = '0;
        for (int i = 0; i < T; i++) begin
            launch_mask[i] = (thread_count > TCW'(i));
            busy[i]        = active_mask[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10);
            if (active_mask[i]) begin
                if (!have_v1) begin
                    v1      = next_pc[i];
                    have_v1 = 1'b1;
                end else if (next_pc[i] != v1) begin
                    if (!have_v2) begin
                        v2      = next_pc[i];
                        have_v2 = 1'b1;
                    end else if (next_pc[i] != v2) begin
                        many = 1'b1;
                    end
                end
            end
        end
        pc_lo   = (have_v2 && v2 < v1) ? v2 : v1;
        pc_hi   = (have_v2 && v2 < v1) ? v1 : v2;
        mask_lo = '0;
        mask_hi = '0;
        for (int i = 0; i < T; i++) begin
            mask_lo[i] = active_mask[i] && (next_pc[i] == pc_lo);
            mask_hi[i] = active_mask[i] && (next_pc[i] == pc_hi);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = current_pc;
        mask_nxt  = active_mask;
        done_nxt  = done;
        error_nxt = error;
        sp_nxt    = sp;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt = launch_mask;
                    if (thread_count == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH:   if (fetcher_state == 3'b010) state_nxt = DECODE;
            DECODE:  state_nxt = REQUEST;
            REQUEST: state_nxt = WAIT;
            WAIT:    if (!(|busy)) state_nxt = EXECUTE;
            EXECUTE: state_nxt = UPDATE;
            UPDATE: begin
                state_nxt = FETCH;
                if (decoded_ret) begin
                    if (sp != '0) begin
                        sp_nxt   = sp - SPW'(1);
                        pc_nxt   = stack_pc[tos_idx];
                        mask_nxt = stack_mask[tos_idx];
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (many) begin
                    error_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (have_v2) begin
                    if (sp == SPW'(STACK_DEPTH)) begin
                        error_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        push     = 1'b1;
                        sp_nxt   = sp + SPW'(1);
                        pc_nxt   = pc_lo;
                        mask_nxt = mask_lo;
                    end
                end else begin
                    pc_nxt = v1;
                    // Uniform step landing on the deferred group's PC merges it back in.
                    if (sp != '0 && stack_pc[tos_idx] == v1) begin
                        sp_nxt   = sp - SPW'(1);
                        mask_nxt = active_mask | stack_mask[tos_idx];
                    end
                end
            end
            DONE: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            current_pc  <= '0;
            active_mask <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            sp          <= '0;
        end else begin
            state       <= state_nxt;
            current_pc  <= pc_nxt;
            active_mask <= mask_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
            sp          <= sp_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_pc[push_idx]   <= pc_hi;
            stack_mask[push_idx] <= mask_hi;
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            diverge_count <= '0;
            wait_cycles   <= '0;
        end else begin
            if (push && diverge_count != 16'hFFFF) diverge_count <= diverge_count + 16'd1;
            if (state == WAIT && wait_cycles != 16'hFFFF) wait_cycles <= wait_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/divergent_scheduler.md
Name: divergent_scheduler

Overview:
Per-core control FSM that sequences FETCH→DECODE→REQUEST→WAIT→EXECUTE→UPDATE for one block of threads and supports branch divergence. Divergence is handled with an active-thread mask and a (PC, mask) reconvergence stack. Sits between the fetcher/decoder/LSUs/per-thread PC units and the core's register/ALU enables, which are gated by active_mask.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes (1..32)
PC_BITS, 8, program counter width
STACK_DEPTH, 4, reconvergence stack entries (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  launch block; sampled only in IDLE
thread_count  in  $clog2(THREADS_PER_BLOCK)+1  live threads in block; lanes >= thread_count never active
fetcher_state  in  3  fetcher FSM state; 3'b010 = FETCHED
decoded_ret  in  1  current instruction is RET
lsu_state  in  2 x THREADS_PER_BLOCK  per-lane LSU state; 2'b01 REQUESTING, 2'b10 WAITING
next_pc  in  PC_BITS x THREADS_PER_BLOCK  per-lane computed next PC
current_pc  out  PC_BITS  PC of running thread group
active_mask  out  THREADS_PER_BLOCK  lanes executing current instruction
core_state  out  3  IDLE 0, FETCH 1, DECODE 2, REQUEST 3, WAIT 4, EXECUTE 5, UPDATE 6, DONE 7
done  out  1  block complete (sticky until reset)
error  out  1  stack overflow or >2 distinct next PCs (sticky until reset)

Behaviour:
- Reset: current_pc=0, active_mask=0, core_state=IDLE, done=0, error=0, stack pointer=0; stack contents don't-care. Reset mid-operation aborts immediately and takes priority over all other events.
- IDLE: on start, active_mask <= lanes [0, thread_count); if thread_count==0, go DONE with done=1; else go FETCH. start is ignored in all other states.
- FETCH: advance to DECODE in the cycle after fetcher_state==3'b010 is sampled.
- DECODE, REQUEST, EXECUTE: one cycle each.
- WAIT: advance to EXECUTE when no *active* lane has lsu_state 01 or 10. Inactive lanes are ignored. Minimum one cycle.
- UPDATE, decoded_ret=1:
  - Stack non-empty: pop; current_pc <= popped PC; active_mask <= popped mask; go FETCH.
  - Stack empty: done <= 1; go DONE.
- UPDATE, decoded_ret=0: evaluate next_pc over active lanes only.
  - One distinct value V: current_pc <= V, mask unchanged.
  - Two distinct values L < H: current_pc <= L; active_mask <= lanes with L; push (H, lanes with H).
  - More than two distinct values: error <= 1; go DONE with done=1.
- Reconvergence: after the UPDATE next-PC decision, if the stack is non-empty and the chosen PC equals the top-of-stack PC:
  - pop, and OR the popped mask into active_mask.
  - Checked once per UPDATE, against the top entry only.
  - Same cycle as a push is not possible: a push implies the top PC is H ≠ L.
- Overflow: a push with STACK_DEPTH entries already held sets error <= 1, done <= 1, go DONE; the stack is not modified.
- UPDATE always goes to FETCH unless it goes to DONE.
- DONE: terminal; all outputs hold until reset.
- Stack entry width: PC_BITS + THREADS_PER_BLOCK. LIFO, registered; push/pop take effect at the UPDATE clock edge.
- PC arithmetic: none; no wrap logic. PC values come from next_pc as given.

Optional Feature:
SCHED_PERF_EN
- Defined: adds outputs diverge_count[15:0] (increments per push) and wait_cycles[15:0] (increments each cycle core_state==WAIT). Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- Uniform flow: THREADS=4, thread_count=4, all next_pc=pc+1, RET at pc 3 → done=1 after 4 UPDATE passes, current_pc=3, active_mask=4'b1111, error=0.
- Partial block: thread_count=3; lane 3 lsu_state=01 held forever → WAIT still exits after 1 cycle; active_mask=4'b0111.
- Divergence/reconverge: at pc 2, next_pc={5,5,3,3} (lanes 3..0) → current_pc=3, mask=0011, stack top (5,1100). Lanes reach pc 5 → mask=1111, stack empty, diverge_count=1 if SCHED_PERF_EN.
- RET pop: diverge as above, lanes 0/1 hit RET at pc 4 → current_pc=5, mask=1100, FETCH, done=0. Second RET → done=1.
- Overflow: STACK_DEPTH=1, two nested divergences → error=1, done=1, core_state=7. Three distinct next_pc {1,2,3,3} → error=1.
- Reset mid-WAIT with an active LSU pending → next cycle core_state=0, mask=0, done=0, error=0. Subsequent start relaunches from pc 0.
